// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared opcode, ALU-op, operand-source and writeback-source codes
// plus the packed control bundle carried in the ID/EX register.
package decode_stage_pkg;

  localparam int unsigned OPC_W = 7;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned WB_W  = 2;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0011;

  localparam logic SRC_REG = 1'b0;
  localparam logic SRC_IMM = 1'b1;
  localparam logic SRC_PC  = 1'b1;

  localparam logic [WB_W-1:0] FROM_ALU = 2'd0;
  localparam logic [WB_W-1:0] FROM_MEM = 2'd1;
  localparam logic [WB_W-1:0] FROM_IMM = 2'd2;
  localparam logic [WB_W-1:0] FROM_PC  = 2'd3;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  typedef struct packed {
    logic             branch;
    logic             jal;
    logic             jalr;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src1;
    logic             alu_src2;
    logic             reg_write;
    logic [ALU_W-1:0] alu_type;
    logic [WB_W-1:0]  reg_src;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// decode_stage_imm_gen: combinational immediate format select and sign extension
// for the RV32 I/S/B/U/J formats; R-type and unknown opcodes yield 0.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm_c
);

  always_comb begin
    imm_c = '0;
    case (instr[6:0])
      OP_I, OP_LOAD, OP_JALR: imm_c = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:               imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:              imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                       instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:       imm_c = {instr[31:12], 12'h000};
      OP_JAL:                 imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                       instr[30:21], 1'b0};
      default:                imm_c = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32 decode into an ID/EX register with load-use bubble, flush and stall counter.
// Define DECODE_STAGE_ILLEGAL_EN to flag illegal instructions (they are also forced to NOP).
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [31:0]           pc_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           pc_out,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [31:0]           imm,
  output logic                  branch,
  output logic                  jal,
  output logic                  jalr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  alu_src1,
  output logic                  alu_src2,
  output logic                  reg_write_enable,
  output logic [3:0]            alu_type,
  output logic [1:0]            reg_src,
  output logic [2:0]            funct3,
  output logic                  illegal,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned FIELD_W = 5;
`ifdef DECODE_STAGE_ILLEGAL_EN
  localparam bit ILLEGAL_EN = 1'b1;
`else
  localparam bit ILLEGAL_EN = 1'b0;
`endif
  // Register-field bits that do not fit in REG_ADDR_W
  localparam logic [FIELD_W-1:0] HI_MASK = ~FIELD_W'((32'd1 << REG_ADDR_W) - 32'd1);

  logic [2:0]            f3_c;
  logic [6:0]            f7_c;
  logic [31:0]           imm_c;
  ctrl_t                 ctrl_c, ctrl_d, ctrl_q;
  logic                  use_rs1_c, use_rs2_c, known_c, funct_ok_c, range_bad_c, kill_c;
  logic [REG_ADDR_W-1:0] rs1_d, rs2_d, rd_d;
  logic                  hazard_c, bubble_c;
  state_t                state_q, state_d;

  assign f3_c = instr[14:12];
  assign f7_c = instr[31:25];

  decode_stage_imm_gen u_imm_gen (
    .instr (instr),
    .imm_c (imm_c)
  );

  // Opcode decode into the control bundle and source-usage flags
  always_comb begin
    ctrl_c     = '0;
    use_rs1_c  = 1'b0;
    use_rs2_c  = 1'b0;
    known_c    = 1'b1;
    funct_ok_c = 1'b1;
    case (instr[6:0])
      OP_R: begin
        use_rs1_c          = 1'b1;
        use_rs2_c          = 1'b1;
        ctrl_c.reg_write   = 1'b1;
        ctrl_c.alu_type    = {instr[30], f3_c};
        funct_ok_c = (f7_c == F7_BASE) ||
                     ((f7_c == F7_ALT) && ((f3_c == 3'b000) || (f3_c == 3'b101)));
      end
      OP_I: begin
        use_rs1_c        = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src2  = SRC_IMM;
        if ((f3_c == 3'b001) || (f3_c == 3'b101)) begin
          ctrl_c.alu_type = {instr[30], f3_c};
          funct_ok_c = (f7_c == F7_BASE) || ((f3_c == 3'b101) && (f7_c == F7_ALT));
        end else begin
          ctrl_c.alu_type = {1'b0, f3_c};
        end
      end
      OP_LOAD: begin
        use_rs1_c        = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src2  = SRC_IMM;
        ctrl_c.alu_type  = ALU_ADD;
        ctrl_c.reg_src   = FROM_MEM;
        funct_ok_c = (f3_c != 3'b011) && (f3_c[2:1] != 2'b11);
      end
      OP_STORE: begin
        use_rs1_c        = 1'b1;
        use_rs2_c        = 1'b1;
        ctrl_c.mem_write = 1'b1;
        ctrl_c.alu_src2  = SRC_IMM;
        ctrl_c.alu_type  = ALU_ADD;
        funct_ok_c = !f3_c[2] && (f3_c[1:0] != 2'b11);
      end
      OP_BRANCH: begin
        use_rs1_c     = 1'b1;
        use_rs2_c     = 1'b1;
        ctrl_c.branch = 1'b1;
        case (f3_c[2:1])
          2'b10:   ctrl_c.alu_type = ALU_SLT;
          2'b11:   ctrl_c.alu_type = ALU_SLTU;
          default: ctrl_c.alu_type = ALU_SUB;
        endcase
        funct_ok_c = (f3_c[2:1] != 2'b01);
      end
      OP_LUI: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_src   = FROM_IMM;
      end
      OP_AUIPC: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src1  = SRC_PC;
        ctrl_c.alu_src2  = SRC_IMM;
      end
      OP_JAL: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.jal       = 1'b1;
        ctrl_c.reg_src   = FROM_PC;
      end
      OP_JALR: begin
        use_rs1_c        = 1'b1;
        ctrl_c.reg_write = 1'b1;
        ctrl_c.jalr      = 1'b1;
        ctrl_c.alu_src2  = SRC_IMM;
        ctrl_c.reg_src   = FROM_PC;
        funct_ok_c = (f3_c == 3'b000);
      end
      default: known_c = 1'b0;
    endcase
  end

  // Legality, NOP forcing and register-address extraction (unused fields read as 0)
  always_comb begin
    range_bad_c = (use_rs1_c && ((instr[19:15] & HI_MASK) != '0)) ||
                  (use_rs2_c && ((instr[24:20] & HI_MASK) != '0)) ||
                  (ctrl_c.reg_write && ((instr[11:7] & HI_MASK) != '0));
    kill_c = ILLEGAL_EN && (!known_c || !funct_ok_c || range_bad_c);
    ctrl_d = kill_c ? '0 : ctrl_c;
    rs1_d  = (use_rs1_c && !kill_c) ? instr[15 +: REG_ADDR_W] : '0;
    rs2_d  = (use_rs2_c && !kill_c) ? instr[20 +: REG_ADDR_W] : '0;
    rd_d   = ctrl_d.reg_write ? instr[7 +: REG_ADDR_W] : '0;
  end

  // Unused sources are already 0 and rd!=0 is required, so plain equality suffices
  assign hazard_c = out_valid && mem_read && (rd != '0) && in_valid &&
                    ((rs1_d == rd) || (rs2_d == rd));

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!flush && hazard_c && out_ready) state_d = BUBBLE;
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_ready = !rst && !flush && !hazard_c && (!out_valid || out_ready);
    bubble_c = (state_q == BUBBLE);
  end

  // ID/EX register and saturating bubble counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      pc_out    <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      imm       <= '0;
      funct3    <= '0;
      illegal   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (bubble_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
        out_valid <= 1'b1;
        ctrl_q    <= ctrl_d;
        pc_out    <= pc_in;
        rs1       <= rs1_d;
        rs2       <= rs2_d;
        rd        <= rd_d;
        imm       <= imm_c;
        funct3    <= f3_c;
        illegal   <= kill_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign branch           = ctrl_q.branch;
  assign jal              = ctrl_q.jal;
  assign jalr             = ctrl_q.jalr;
  assign mem_read         = ctrl_q.mem_read;
  assign mem_write        = ctrl_q.mem_write;
  assign alu_src1         = ctrl_q.alu_src1;
  assign alu_src2         = ctrl_q.alu_src2;
  assign reg_write_enable = ctrl_q.reg_write;
  assign alu_type         = ctrl_q.alu_type;
  assign reg_src          = ctrl_q.reg_src;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage for the five-stage RV32 pipeline. It sits between IF/ID and EX. Each cycle it decodes one instruction into the full control bundle plus the sign-extended immediate, and holds the result in the ID/EX register behind a valid/ready handshake. On top of plain decoding it adds a parametrised register-file width (RV32I or RV32E), load-use hazard bubble insertion, branch flush, and a saturating stall counter.

## Interface
Parameters:
- REG_ADDR_W, default 5: register address width. 5 selects RV32I, 4 selects RV32E. Operand/dest fields wider than this are out of range.
- CNT_W, default 16: width of the stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  IF/ID holds an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- instr  in  32  instruction word.
- pc_in  in  32  PC of instr.
- flush  in  1  branch/jump resolved taken in EX; squash the stage.
- out_valid  out  1  ID/EX register holds a decoded instruction.
- out_ready  in  1  EX accepts the contents.
- pc_out  out  32  registered PC.
- rs1, rs2, rd  out  REG_ADDR_W each  register addresses. Unused fields are 0; rd is 0 when reg_write_enable=0.
- imm  out  32  sign-extended immediate for the I/S/B/U/J formats.
- branch, jal, jalr, mem_read, mem_write, alu_src1, alu_src2, reg_write_enable  out  1 each  control flags.
- alu_type  out  4  ALU op.
- reg_src  out  2  writeback source: ALU, MEM, IMM or PC.
- funct3  out  3  raw funct3 field.
- illegal  out  1  illegal instruction (only with the macro; tied 0 otherwise).
- stall_cnt  out  CNT_W  count of load-use bubbles inserted.

## Operation
- Decode rules, per opcode:
  - R: alu_type={instr[30],funct3}, both sources REG.
  - I-ALU: shifts use {instr[30],funct3}, everything else uses {0,funct3}.
  - Load/Store: ADD, src2 IMM.
  - Branch: SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
  - LUI: reg_src=IMM.
  - AUIPC: src1=PC, src2=IMM.
  - JAL/JALR: reg_src=PC.
  - Unknown opcode: NOP, i.e. all enables 0.
- Register addresses are the low REG_ADDR_W bits of the instruction fields.
- Load-use hazard is true when all of the following hold:
  - out_valid and mem_read;
  - rd≠0;
  - in_valid;
  - the incoming instruction reads rd via rs1 or rs2 (only the sources that instruction actually uses).
- States: RUN and BUBBLE.
  - RUN: a transfer happens when in_valid & in_ready. The register loads the new decode and sets out_valid=1.
  - RUN to BUBBLE: the hazard is true and out_ready=1. The load leaves the register; out_valid becomes 0 next cycle and in_ready=0.
  - BUBBLE: stall_cnt increments, saturating at all-ones. Return to RUN next cycle unconditionally.
  - If the hazard holds while out_ready=0, the stage stays in RUN and simply holds (in_ready=0). No bubble is counted.
- in_ready = ~rst & ~flush & ~hazard & (~out_valid | out_ready).
- When out_valid & ~out_ready and no new transfer occurs, the register holds its contents.
- flush: out_valid becomes 0 next cycle, the state goes to RUN, and the in-flight input is dropped. flush has priority over hazard and transfer. stall_cnt is unaffected.
- rst: every output register and stall_cnt goes to 0 and the state goes to RUN. rst mid-stall aborts the bubble.

## Timing
- Latency is 1 cycle from accept to out_valid. Throughput is 1 per cycle with no hazard.
- Reset values: out_valid=0; all control outputs, imm, pc_out, rs1/rs2/rd, alu_type, reg_src, funct3, illegal and stall_cnt are 0.
- in_ready is combinational from out_ready, flush and the hazard; there is no combinational path from instr to out_valid.
- A load-use pair costs exactly 1 bubble cycle.
- Simultaneous flush and out_ready=1: the content leaves and the register goes empty.

## Configuration
- DECODE_STAGE_ILLEGAL_EN defined: illegal=1 (registered with the decode) for any of the following. Illegal instructions are also forced to NOP, with all enables 0.
  - unknown opcode;
  - bad funct3/funct7 combination;
  - any used rs1/rs2/rd field with bits above REG_ADDR_W set.
- DECODE_STAGE_ILLEGAL_EN undefined: illegal is tied 0. Unknown opcodes decode to NOP, and out-of-range register fields are truncated.

## Structure
- Opcode constants, ALU op codes, REG/IMM/PC source codes and FROM_* writeback codes live in the shared defines file. No new local copies.
- One sub-module, imm_gen: combinational format select and sign extension, 32-bit in, 32-bit out.
- The top holds the decode, hazard logic, two-state FSM, ID/EX register and counter.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093): next cycle out_valid=1, rd=1, rs1=0, imm=5, alu_src2=IMM, reg_write_enable=1, alu_type=0000.
- addi x1,x0,-1 (0xFFF00093): imm=0xFFFFFFFF.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x2 (0x00228333), out_ready held 1:
  - the add is held one cycle with in_ready=0 and one out_valid=0 cycle between them;
  - stall_cnt=1;
  - the add then emerges with rs1=5, rs2=2.
- Same load-use pair with out_ready=0 for 3 cycles: the lw is held and stall_cnt stays 0; on release, exactly one bubble is inserted.
- flush asserted while the register holds add x6,x5,x2 and in_valid=1: next cycle out_valid=0 and the input is not consumed.
- REG_ADDR_W=4, add x16,x0,x0 (0x00000833):
  - with DECODE_STAGE_ILLEGAL_EN, illegal=1 and reg_write_enable=0;
  - without the macro, rd=0 (truncated) and illegal=0.
